// File: rtl/npc_pkg.sv
// Shared definitions for the npc core control path: opcodes, FSM state
// encodings and trap cause codes.
`timescale 1ns/1ps
package npc_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;

  typedef logic [2:0] state_t;
  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_WB     = 3'd4;
  localparam state_t ST_HALT   = 3'd5;
  localparam state_t ST_TRAP   = 3'd6;

  typedef logic [1:0] cause_t;
  localparam cause_t CAUSE_NONE     = 2'd0;
  localparam cause_t CAUSE_ILLEGAL  = 2'd1;
  localparam cause_t CAUSE_FETCH_TO = 2'd2;
  localparam cause_t CAUSE_LSU_TO   = 2'd3;

endpackage

// File: rtl/npc_ctrl_fsm_if.sv
// Instruction-fetch and load/store handshakes between the control sequencer
// (master) and the memory side (slave).
`timescale 1ns/1ps
interface npc_ctrl_fsm_if;
  logic        ifetch_req;
  logic        ifetch_ack;
  logic [31:0] ifetch_rdata;
  logic        lsu_req;
  logic        lsu_we;
  logic        lsu_ack;

  modport master (
    output ifetch_req,
    input  ifetch_ack,
    input  ifetch_rdata,
    output lsu_req,
    output lsu_we,
    input  lsu_ack
  );

  modport slave (
    input  ifetch_req,
    output ifetch_ack,
    output ifetch_rdata,
    input  lsu_req,
    input  lsu_we,
    output lsu_ack
  );
endinterface

// File: rtl/npc_opc_class.sv
// Combinational opcode classifier: legality, memory access, store and
// destination-register write for the major opcode field.
`timescale 1ns/1ps
module npc_opc_class
  import npc_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       legal,
  output logic       is_mem,
  output logic       is_store,
  output logic       writes_rd
);

  always_comb begin
    legal     = 1'b0;
    is_mem    = 1'b0;
    is_store  = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        legal     = 1'b1;
        is_mem    = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_STORE: begin
        legal    = 1'b1;
        is_mem   = 1'b1;
        is_store = 1'b1;
      end
      OPC_BRANCH: legal = 1'b1;
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_OP, OPC_OP_32,
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
        legal     = 1'b1;
        writes_rd = 1'b1;
      end
      // SYSTEM is deliberately absent: only the exact ebreak word is accepted
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the npc RV64 core, with
// ebreak halt, illegal-opcode trap and bus-timeout traps.
`timescale 1ns/1ps
module npc_ctrl_fsm
  import npc_pkg::*;
#(
  parameter int TIMEOUT_W = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  npc_ctrl_fsm_if.master      bus,
  output logic [31:0]         ir,
  output logic                rf_we,
  output logic                pc_we,
  output logic [2:0]          state,
  output logic                halted,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [63:0]         instret
);

  logic [TIMEOUT_W-1:0] wait_cnt;
  state_t               state_nxt;
  cause_t               cause_nxt;
  logic                 opc_legal, opc_mem, opc_store, opc_wrd;
  logic                 timeout_hit;

  npc_opc_class u_opc_class (
    .opcode    (ir[6:0]),
    .legal     (opc_legal),
    .is_mem    (opc_mem),
    .is_store  (opc_store),
    .writes_rd (opc_wrd)
  );

  // The cycle that would take the counter to TIMEOUT is the trap cycle, so a
  // request waits TIMEOUT cycles in total; an ack in that cycle still wins.
  assign timeout_hit = (wait_cnt == TIMEOUT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    cause_nxt = trap_cause;
    case (state)
      ST_FETCH: begin
        if (bus.ifetch_ack) begin
          state_nxt = ST_DECODE;
        end else if (timeout_hit) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_FETCH_TO;
        end
      end
      ST_DECODE: begin
        if (ir == EBREAK_INST) begin
          state_nxt = ST_HALT;
        end else if (opc_legal) begin
          state_nxt = ST_EXEC;
        end else begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: state_nxt = opc_mem ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (bus.lsu_ack) begin
          state_nxt = ST_WB;
        end else if (timeout_hit) begin
          state_nxt = ST_TRAP;
          cause_nxt = CAUSE_LSU_TO;
        end
      end
      ST_WB:   state_nxt = ST_FETCH;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_FETCH;
      ir         <= NOP_INST;
      instret    <= 64'd0;
      trap_cause <= CAUSE_NONE;
      wait_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      trap_cause <= cause_nxt;
      if (state == ST_FETCH && bus.ifetch_ack) begin
        ir <= bus.ifetch_rdata;
      end
      if (state_nxt != state) begin
        wait_cnt <= '0;
      end else if (state == ST_FETCH || state == ST_MEM) begin
        wait_cnt <= wait_cnt + TIMEOUT_W'(1);
      end
      // ebreak retires on its way into HALT; trapped instructions never retire
      if (state == ST_WB || (state == ST_DECODE && state_nxt == ST_HALT)) begin
        instret <= instret + 64'd1;
      end
    end
  end

  // Requests and strobes are forced low while reset is asserted
  assign bus.ifetch_req = rst_n && (state == ST_FETCH);
  assign bus.lsu_req    = rst_n && (state == ST_MEM);
  assign bus.lsu_we     = bus.lsu_req && opc_store;
  assign pc_we          = rst_n && (state == ST_WB);
  assign rf_we          = pc_we && opc_wrd && (ir[11:7] != 5'd0);
  assign halted         = (state == ST_HALT);
  assign trap           = (state == ST_TRAP);

endmodule

// File: tb/tb_npc_ctrl_fsm.sv
// Directed bench for npc_ctrl_fsm: normal ALU/load/store flow, ebreak halt,
// illegal-opcode trap, fetch/LSU timeouts and reset in mid-transaction.
`timescale 1ns/1ps
module tb_npc_ctrl_fsm;

  logic        clk;
  logic        rst_n;
  logic [31:0] ir;
  logic        rf_we, pc_we, halted, trap;
  logic [2:0]  state;
  logic [1:0]  trap_cause;
  logic [63:0] instret;
  int          n_cmp;
  int          n_fail;

  npc_ctrl_fsm_if bus();

  npc_ctrl_fsm #(.TIMEOUT_W(4), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .ir         (ir),
    .rf_we      (rf_we),
    .pc_we      (pc_we),
    .state      (state),
    .halted     (halted),
    .trap       (trap),
    .trap_cause (trap_cause),
    .instret    (instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.ifetch_ack = 1'b0;
    bus.lsu_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Leaves the FSM in DECODE with the word latched
  task automatic fetch(input logic [31:0] word, input int gap);
    repeat (gap) tick();
    bus.ifetch_ack = 1'b1;
    bus.ifetch_rdata = word;
    tick();
    bus.ifetch_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ifetch_ack = 1'b0;
    bus.lsu_ack = 1'b0;
    bus.ifetch_rdata = 32'h0;
    tick();
    tick();
    n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state); end
    n_cmp++; if (ir !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_ir: got %h want 00000013", ir); end
    n_cmp++; if (instret !== 64'd0) begin n_fail++; $display("FAIL rst_instret: got %0d want 0", instret); end
    n_cmp++; if ({halted, trap, trap_cause} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {halted, trap, trap_cause}); end
    n_cmp++; if ({bus.ifetch_req, bus.lsu_req, rf_we, pc_we} !== 4'b0000) begin n_fail++; $display("FAIL rst_strobes: got %b want 0000", {bus.ifetch_req, bus.lsu_req, rf_we, pc_we}); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.ifetch_req !== 1'b1) begin n_fail++; $display("FAIL rst_release_req: got %b want 1", bus.ifetch_req); end
  endtask

  task automatic test_alu();
    fetch(32'h0050_0093, 2);
    n_cmp++; if (ir !== 32'h0050_0093) begin n_fail++; $display("FAIL alu_ir: got %h want 00500093", ir); end
    n_cmp++; if (state !== 3'd1) begin n_fail++; $display("FAIL alu_decode: got %0d want 1", state); end
    n_cmp++; if (bus.ifetch_req !== 1'b0) begin n_fail++; $display("FAIL alu_req_drop: got %b want 0", bus.ifetch_req); end
    tick();
    n_cmp++; if (state !== 3'd2) begin n_fail++; $display("FAIL alu_exec: got %0d want 2", state); end
    n_cmp++; if ({rf_we, pc_we} !== 2'b00) begin n_fail++; $display("FAIL alu_exec_strobes: got %b want 00", {rf_we, pc_we}); end
    tick();
    n_cmp++; if (state !== 3'd4) begin n_fail++; $display("FAIL alu_wb: got %0d want 4", state); end
    n_cmp++; if ({rf_we, pc_we} !== 2'b11) begin n_fail++; $display("FAIL alu_wb_strobes: got %b want 11", {rf_we, pc_we}); end
    tick();
    n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL alu_back_fetch: got %0d want 0", state); end
    n_cmp++; if (instret !== 64'd1) begin n_fail++; $display("FAIL alu_instret: got %0d want 1", instret); end
  endtask

  task automatic test_store();
    fetch(32'h0011_3023, 0);
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({state, bus.lsu_req, bus.lsu_we, bus.ifetch_req} !== {3'd3, 3'b110}) begin
        n_fail++; $display("FAIL st_mem%0d: got st=%0d req=%b we=%b ireq=%b want st=3 req=1 we=1 ireq=0", i, state, bus.lsu_req, bus.lsu_we, bus.ifetch_req);
      end
      if (i == 2) bus.lsu_ack = 1'b1;
      tick();
    end
    bus.lsu_ack = 1'b0;
    n_cmp++; if (state !== 3'd4) begin n_fail++; $display("FAIL st_wb: got %0d want 4", state); end
    n_cmp++; if ({rf_we, pc_we, bus.lsu_req} !== 3'b010) begin n_fail++; $display("FAIL st_wb_strobes: got %b want 010", {rf_we, pc_we, bus.lsu_req}); end
    tick();
    n_cmp++; if (instret !== 64'd2) begin n_fail++; $display("FAIL st_instret: got %0d want 2", instret); end
  endtask

  task automatic test_load();
    fetch(32'h0001_3183, 0);
    tick();
    tick();
    n_cmp++; if ({state, bus.lsu_req, bus.lsu_we} !== {3'd3, 2'b10}) begin n_fail++; $display("FAIL ld_mem: got st=%0d req=%b we=%b want st=3 req=1 we=0", state, bus.lsu_req, bus.lsu_we); end
    bus.lsu_ack = 1'b1;
    tick();
    bus.lsu_ack = 1'b0;
    n_cmp++; if ({state, rf_we, pc_we} !== {3'd4, 2'b11}) begin n_fail++; $display("FAIL ld_wb: got st=%0d rf_we=%b pc_we=%b want st=4 11", state, rf_we, pc_we); end
    tick();
    n_cmp++; if (instret !== 64'd3) begin n_fail++; $display("FAIL ld_instret: got %0d want 3", instret); end
  endtask

  task automatic test_illegal();
    fetch(32'hFFFF_FFFF, 0);
    tick();
    n_cmp++; if ({state, trap, trap_cause} !== {3'd6, 1'b1, 2'd1}) begin n_fail++; $display("FAIL ill_trap: got st=%0d trap=%b cause=%0d want st=6 trap=1 cause=1", state, trap, trap_cause); end
    for (int i = 0; i < 4; i++) begin
      bus.ifetch_ack = 1'b1;
      bus.lsu_ack = 1'b1;
      tick();
      n_cmp++; if ({state, bus.ifetch_req, bus.lsu_req} !== {3'd6, 2'b00}) begin n_fail++; $display("FAIL ill_sticky%0d: got st=%0d ireq=%b lreq=%b want st=6 00", i, state, bus.ifetch_req, bus.lsu_req); end
    end
    bus.ifetch_ack = 1'b0;
    bus.lsu_ack = 1'b0;
    n_cmp++; if (instret !== 64'd3) begin n_fail++; $display("FAIL ill_instret: got %0d want 3", instret); end
  endtask

  task automatic test_ebreak();
    do_reset();
    fetch(32'h0010_0073, 1);
    tick();
    n_cmp++; if ({state, halted, trap} !== {3'd5, 2'b10}) begin n_fail++; $display("FAIL eb_halt: got st=%0d halted=%b trap=%b want st=5 10", state, halted, trap); end
    n_cmp++; if (instret !== 64'd1) begin n_fail++; $display("FAIL eb_instret: got %0d want 1", instret); end
    repeat (5) tick();
    n_cmp++; if ({halted, bus.ifetch_req, rf_we, pc_we} !== 4'b1000) begin n_fail++; $display("FAIL eb_sticky: got %b want 1000", {halted, bus.ifetch_req, rf_we, pc_we}); end
    n_cmp++; if (instret !== 64'd1) begin n_fail++; $display("FAIL eb_instret_once: got %0d want 1", instret); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    n = 0;
    while (state == 3'd0 && n < 40) begin
      tick();
      n++;
    end
    n_cmp++; if (n !== 15) begin n_fail++; $display("FAIL fto_cycles: got %0d want 15", n); end
    n_cmp++; if ({state, trap, trap_cause} !== {3'd6, 1'b1, 2'd2}) begin n_fail++; $display("FAIL fto_trap: got st=%0d trap=%b cause=%0d want st=6 1 2", state, trap, trap_cause); end
    // ack arriving in the last permitted cycle beats the timeout
    do_reset();
    fetch(32'h0050_0093, 14);
    n_cmp++; if (state !== 3'd1) begin n_fail++; $display("FAIL fto_ack_wins: got %0d want 1", state); end
    do_reset();
    fetch(32'h0001_3183, 0);
    tick();
    tick();
    n = 0;
    while (state == 3'd3 && n < 40) begin
      tick();
      n++;
    end
    n_cmp++; if (n !== 15) begin n_fail++; $display("FAIL lto_cycles: got %0d want 15", n); end
    n_cmp++; if ({state, trap_cause, bus.lsu_req} !== {3'd6, 2'd3, 1'b0}) begin n_fail++; $display("FAIL lto_trap: got st=%0d cause=%0d lreq=%b want st=6 3 0", state, trap_cause, bus.lsu_req); end
    n_cmp++; if (instret !== 64'd0) begin n_fail++; $display("FAIL lto_instret: got %0d want 0", instret); end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    fetch(32'h0050_0093, 0);
    tick();
    tick();
    tick();
    fetch(32'h0011_3023, 0);
    tick();
    tick();
    n_cmp++; if ({state, bus.lsu_req} !== {3'd3, 1'b1}) begin n_fail++; $display("FAIL rm_in_mem: got st=%0d lreq=%b want st=3 1", state, bus.lsu_req); end
    rst_n = 1'b0;
    bus.lsu_ack = 1'b1;
    #1;
    n_cmp++; if ({bus.lsu_req, bus.lsu_we, rf_we, pc_we} !== 4'b0000) begin n_fail++; $display("FAIL rm_gated: got %b want 0000", {bus.lsu_req, bus.lsu_we, rf_we, pc_we}); end
    tick();
    bus.lsu_ack = 1'b0;
    rst_n = 1'b1;
    n_cmp++; if ({state, trap, halted, trap_cause} !== {3'd0, 4'b0000}) begin n_fail++; $display("FAIL rm_state: got st=%0d flags=%b want st=0 0000", state, {trap, halted, trap_cause}); end
    n_cmp++; if ({ir, instret} !== {32'h0000_0013, 64'd0}) begin n_fail++; $display("FAIL rm_regs: got ir=%h instret=%0d want 00000013 0", ir, instret); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.ifetch_ack = 1'b0;
    bus.lsu_ack = 1'b0;
    bus.ifetch_rdata = 32'h0;
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_illegal();
    test_ebreak();
    test_timeout();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
